// File: rtl/bram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_pipe
// Brief    : Single-clock dual-port RAM (A read/write, B read-only) with
//            configurable read-during-write, cross-port forwarding, optional
//            output register and per-port read-valid strobes.
// Revision : 1.0
// ============================================================================
module bram_sdp_pipe #(
    parameter int ADDR_WIDTH = 18,
    parameter int BIT_WIDTH  = 8,
    parameter int OUT_REG    = 0,
    parameter int RD_MODE    = 0,
    parameter int COLL_MODE  = 0
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [BIT_WIDTH-1:0]  dina,
    output logic [BIT_WIDTH-1:0]  douta,
    output logic                  douta_vld,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [BIT_WIDTH-1:0]  doutb,
    output logic                  doutb_vld
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [BIT_WIDTH-1:0] ram_a_q, ram_b_q;

    logic mem_we, rd_a_en, rd_b_en;

    logic                 vld_a1_q, vld_a1_d, vld_b1_q, vld_b1_d;
    logic                 have_a_q, have_a_d, have_b_q, have_b_d;
    logic                 fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [BIT_WIDTH-1:0] fdat_a_q, fdat_a_d, fdat_b_q, fdat_b_d;
    logic [BIT_WIDTH-1:0] s1_a, s1_b;

    // Array and its read registers carry no reset so they map onto block RAM;
    // reading in the same process as the write gives read-first behaviour.
    always_ff @(posedge clka) begin
        if (mem_we)  mem[addra] <= dina;
        if (rd_a_en) ram_a_q    <= mem[addra];
        if (rd_b_en) ram_b_q    <= mem[addrb];
    end

    always_comb begin
        mem_we   = rsta_n & ena & wea;
        rd_a_en  = rsta_n & ena;
        rd_b_en  = rsta_n & enb;

        vld_a1_d = ena;
        vld_b1_d = enb;
        have_a_d = have_a_q | ena;
        have_b_d = have_b_q | enb;

        fwd_a_d  = fwd_a_q;
        fdat_a_d = fdat_a_q;
        fwd_b_d  = fwd_b_q;
        fdat_b_d = fdat_b_q;
        if (ena) begin
            fwd_a_d  = (RD_MODE != 0) && wea;
            fdat_a_d = dina;
        end
        if (enb) begin
            fwd_b_d  = (COLL_MODE != 0) && ena && wea && (addra == addrb);
            fdat_b_d = dina;
        end

        // have_* masks the unreset RAM register until the first access after reset
        s1_a = have_a_q ? (fwd_a_q ? fdat_a_q : ram_a_q) : '0;
        s1_b = have_b_q ? (fwd_b_q ? fdat_b_q : ram_b_q) : '0;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_a1_q <= 1'b0;
            vld_b1_q <= 1'b0;
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
            fwd_a_q  <= 1'b0;
            fwd_b_q  <= 1'b0;
            fdat_a_q <= '0;
            fdat_b_q <= '0;
        end else begin
            vld_a1_q <= vld_a1_d;
            vld_b1_q <= vld_b1_d;
            have_a_q <= have_a_d;
            have_b_q <= have_b_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            fdat_a_q <= fdat_a_d;
            fdat_b_q <= fdat_b_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [BIT_WIDTH-1:0] douta_q, douta_d, doutb_q, doutb_d;
            logic                 vld_a2_q, vld_a2_d, vld_b2_q, vld_b2_d;

            always_comb begin
                douta_d  = vld_a1_q ? s1_a : douta_q;
                doutb_d  = vld_b1_q ? s1_b : doutb_q;
                vld_a2_d = vld_a1_q;
                vld_b2_d = vld_b1_q;
            end

            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    douta_q  <= '0;
                    doutb_q  <= '0;
                    vld_a2_q <= 1'b0;
                    vld_b2_q <= 1'b0;
                end else begin
                    douta_q  <= douta_d;
                    doutb_q  <= doutb_d;
                    vld_a2_q <= vld_a2_d;
                    vld_b2_q <= vld_b2_d;
                end
            end

            assign douta     = douta_q;
            assign doutb     = doutb_q;
            assign douta_vld = vld_a2_q;
            assign doutb_vld = vld_b2_q;
        end else begin : g_no_out_reg
            assign douta     = s1_a;
            assign doutb     = s1_b;
            assign douta_vld = vld_a1_q;
            assign doutb_vld = vld_b1_q;
        end
    endgenerate

endmodule
`default_nettype wire
